// File: rtl/sync_down_counter.sv
// Synchronous down counter with parallel load, count enable, terminal-count pulse
// and wrap/one-shot modes. Define DOWN_CNT_PRESCALE_EN to divide the enable by PRESCALE.
module sync_down_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    if (WIDTH < 2 || PRESCALE < 2) begin : g_bad_param
        $error("sync_down_counter: WIDTH and PRESCALE must both be at least 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             step_c;

`ifdef DOWN_CNT_PRESCALE_EN
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Only the enabled cycle that completes a prescale interval advances the count
    assign step_c = en && (pre_q == PRE_MAX);
`else
    assign step_c = en;
`endif

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
`ifdef DOWN_CNT_PRESCALE_EN
        pre_d   = pre_q;
`endif

        if (load) begin
            cnt_d   = load_val;
            state_d = ((load_val == '0) && oneshot) ? ST_DONE : ST_RUN;
`ifdef DOWN_CNT_PRESCALE_EN
            pre_d   = '0;
`endif
        end else begin
            unique case (state_q)
                ST_RUN: begin
`ifdef DOWN_CNT_PRESCALE_EN
                    if (en) begin
                        pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
                    end
`endif
                    if (step_c) begin
                        if (cnt_q == '0) begin
                            // Sitting at zero: wrap, or expire silently if one-shot was just selected
                            if (oneshot) begin
                                state_d = ST_DONE;
                            end else begin
                                cnt_d = ALL_ONES;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                            if (cnt_q == CNT_ONE) begin
                                tc_d = 1'b1;
                                if (oneshot) begin
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= ALL_ONES;
            tc_q    <= 1'b0;
            busy_q  <= 1'b1;
`ifdef DOWN_CNT_PRESCALE_EN
            pre_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
`ifdef DOWN_CNT_PRESCALE_EN
            pre_q   <= pre_d;
`endif
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter (WIDTH=4, PRESCALE=4).
// Counting scenarios depend on whether DOWN_CNT_PRESCALE_EN is defined.
module tb_sync_down_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    int checks = 0;
    int errors = 0;

    sync_down_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .oneshot  (oneshot),
        .q        (q),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1; load_val = v; step(); load = 1'b0;
    endtask

    task automatic test_reset();
        idle(); oneshot = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        checks++; if (q !== 4'hF)  begin errors++; $display("FAIL reset_q: got %h exp F", q); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b exp 0", tc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b exp 1", busy); end
    endtask

    task automatic test_load_priority();
        idle(); oneshot = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'h9; step();
        checks++; if (q !== 4'h9)  begin errors++; $display("FAIL loadpri_q: got %h exp 9", q); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL loadpri_tc: got %b exp 0", tc); end
        oneshot = 1'b1; load_val = 4'h0; step(); load = 1'b0; en = 1'b0;
        checks++; if (q !== 4'h0)    begin errors++; $display("FAIL zeroload_q: got %h exp 0", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zeroload_busy: got %b exp 0", busy); end
        checks++; if (tc !== 1'b0)   begin errors++; $display("FAIL zeroload_tc: got %b exp 0", tc); end
    endtask

    task automatic test_reset_mid();
        idle(); oneshot = 1'b0; do_load(4'h6);
        rst = 1'b1; load = 1'b1; load_val = 4'hA; en = 1'b1; step(); idle();
        checks++; if (q !== 4'hF)    begin errors++; $display("FAIL rstmid_q: got %h exp F", q); end
        checks++; if (tc !== 1'b0)   begin errors++; $display("FAIL rstmid_tc: got %b exp 0", tc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b exp 1", busy); end
    endtask

`ifndef DOWN_CNT_PRESCALE_EN
    task automatic test_wrap();
        logic [WIDTH-1:0] exp_q;
        idle(); oneshot = 1'b0; rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_q = WIDTH'(15 - i);
            checks++; if (q !== exp_q) begin errors++; $display("FAIL wrap_q[%0d]: got %h exp %h", i, q, exp_q); end
            checks++; if (tc !== (i == 15)) begin errors++; $display("FAIL wrap_tc[%0d]: got %b exp %b", i, tc, (i == 15)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy[%0d]: got %b exp 1", i, busy); end
        end
        en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [WIDTH-1:0] exp_q;
        idle(); oneshot = 1'b1; do_load(4'h3);
        checks++; if (q !== 4'h3) begin errors++; $display("FAIL os_load_q: got %h exp 3", q); end
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_q = (i < 3) ? WIDTH'(3 - i) : 4'h0;
            checks++; if (q !== exp_q) begin errors++; $display("FAIL os_q[%0d]: got %h exp %h", i, q, exp_q); end
            checks++; if (tc !== (i == 3)) begin errors++; $display("FAIL os_tc[%0d]: got %b exp %b", i, tc, (i == 3)); end
            checks++; if (busy !== (i < 3)) begin errors++; $display("FAIL os_busy[%0d]: got %b exp %b", i, busy, (i < 3)); end
        end
        en = 1'b0;
    endtask

    task automatic test_enable_gating();
        logic [WIDTH-1:0] exp_seq [4];
        exp_seq = '{4'h4, 4'h4, 4'h3, 4'h3};
        idle(); oneshot = 1'b0; do_load(4'h5);
        for (int i = 0; i < 4; i++) begin
            en = (i % 2 == 0); step();
            checks++; if (q !== exp_seq[i]) begin errors++; $display("FAIL gate_q[%0d]: got %h exp %h", i, q, exp_seq[i]); end
        end
        oneshot = 1'b1; do_load(4'h0);
        en = 1'b1; step(); step();
        checks++; if (q !== 4'h0)    begin errors++; $display("FAIL done_hold_q: got %h exp 0", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_hold_busy: got %b exp 0", busy); end
        checks++; if (tc !== 1'b0)   begin errors++; $display("FAIL done_hold_tc: got %b exp 0", tc); end
        en = 1'b0; do_load(4'h2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_exit_busy: got %b exp 1", busy); end
        checks++; if (q !== 4'h2)    begin errors++; $display("FAIL done_exit_q: got %h exp 2", q); end
        en = 1'b1; step();
        checks++; if (q !== 4'h1)    begin errors++; $display("FAIL resume_q1: got %h exp 1", q); end
        step();
        checks++; if (q !== 4'h0)    begin errors++; $display("FAIL resume_q0: got %h exp 0", q); end
        checks++; if (tc !== 1'b1)   begin errors++; $display("FAIL resume_tc: got %b exp 1", tc); end
        en = 1'b0;
    endtask

    task automatic test_zero_mode_change();
        idle(); oneshot = 1'b0; do_load(4'h0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zwrap_busy0: got %b exp 1", busy); end
        en = 1'b1; step();
        checks++; if (q !== 4'hF)    begin errors++; $display("FAIL zwrap_q: got %h exp F", q); end
        checks++; if (tc !== 1'b0)   begin errors++; $display("FAIL zwrap_tc: got %b exp 0", tc); end
        en = 1'b0; do_load(4'h0);
        oneshot = 1'b1; en = 1'b1; step(); en = 1'b0;
        checks++; if (q !== 4'h0)    begin errors++; $display("FAIL zos_q: got %h exp 0", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zos_busy: got %b exp 0", busy); end
        checks++; if (tc !== 1'b0)   begin errors++; $display("FAIL zos_tc: got %b exp 0", tc); end
    endtask
`else
    task automatic test_prescale();
        logic [WIDTH-1:0] exp_q;
        idle(); oneshot = 1'b1; do_load(4'h2); en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_q = (i < 4) ? 4'h2 : (i < 8) ? 4'h1 : 4'h0;
            checks++; if (q !== exp_q) begin errors++; $display("FAIL pre_q[%0d]: got %h exp %h", i, q, exp_q); end
            checks++; if (tc !== (i == 8)) begin errors++; $display("FAIL pre_tc[%0d]: got %b exp %b", i, tc, (i == 8)); end
        end
        oneshot = 1'b0; do_load(4'h5);
        step(); step();
        do_load(4'h5);
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_q = (i < 4) ? 4'h5 : 4'h4;
            checks++; if (q !== exp_q) begin errors++; $display("FAIL pre_restart_q[%0d]: got %h exp %h", i, q, exp_q); end
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        idle(); oneshot = 1'b0;
        test_reset();
`ifndef DOWN_CNT_PRESCALE_EN
        test_wrap();
        test_oneshot();
`endif
        test_load_priority();
`ifndef DOWN_CNT_PRESCALE_EN
        test_enable_gating();
        test_zero_mode_change();
`else
        test_prescale();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous, parameterised down counter; the counting-direction counterpart of the existing ripple up counter.
- All bits change on one clock edge, so there are no ripple glitches.
- Adds parallel load, count enable, terminal-count pulse, and wrap or one-shot modes.
- Used as a timeout/interval timer next to the up counter in the counter library.

Parameters:
- WIDTH, 4, counter width in bits (min 2).
- PRESCALE, 4, clock-enable divide ratio; only used when DOWN_CNT_PRESCALE_EN is defined (min 2).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- en  input  1  count enable; one decrement per enabled cycle.
- load  input  1  parallel load strobe; priority over en.
- load_val  input  WIDTH  value written to q on load.
- oneshot  input  1  1 = stop at zero, 0 = wrap from 0 to all-ones.
- q  output  WIDTH  registered count value.
- tc  output  1  registered terminal-count pulse.
- busy  output  1  high while state is RUN.

Behaviour:
- Reset (rst=1 at edge), overriding everything else:
  - q = all ones (4'hF for WIDTH=4).
  - tc = 0, busy = 1, state = RUN.
  - Prescaler cleared.
- States:
  - RUN: counting allowed.
  - DONE: one-shot has expired; q holds 0, busy = 0.
- Edge priority: rst > load > en.
- Load (load=1, any state):
  - q <= load_val; tc <= 0; prescaler cleared.
  - Next state RUN if load_val != 0.
  - Next state DONE if load_val == 0 and oneshot = 1.
  - Next state RUN if load_val == 0 and oneshot = 0.
  - A load never generates tc.
- RUN, en=1, load=0:
  - q != 0: q <= q - 1 (mod 2^WIDTH).
  - q == 1: q <= 0 and tc <= 1 for exactly that one cycle. If oneshot = 1, next state is DONE.
  - q == 0 and oneshot = 0: q <= all ones (wrap), tc <= 0, stay RUN.
  - q == 0 and oneshot = 1 (mode changed while sitting at 0): q holds 0, next state DONE, no tc.
- RUN, en=0: q holds; tc <= 0.
- DONE: q holds 0; en ignored; tc <= 0; only load or rst leave DONE.
- tc timing:
  - tc is a one-cycle pulse, never held high across consecutive cycles.
  - In wrap mode with en held high, tc pulses once every 2^WIDTH cycles.
- oneshot is sampled every cycle and is not latched.
- Reset mid-count: takes effect at the next edge and overrides load and en.
- Latency:
  - q and busy update on the edge following their cause.
  - tc is coincident with q becoming 0 by decrement.

Optional Feature:
- Macro: DOWN_CNT_PRESCALE_EN.
- Defined:
  - An internal modulo-PRESCALE prescaler counts cycles with en=1.
  - A decrement (with its tc and wrap rules) happens only on the en cycle where the prescaler reaches PRESCALE-1; the prescaler then returns to 0.
  - Prescaler is cleared on rst and on load, and holds while en=0 or while in DONE.
- Not defined: no prescaler logic exists; every en=1 cycle in RUN decrements, as above.

Test Plan:
- Reset, then wrap mode: rst=1 for one edge, oneshot=0, en=1 for 16 cycles -> q goes F,E,...,1,0,F; tc=1 only in the cycle q=0; busy=1 throughout.
- One-shot expiry: load=1 with load_val=3, oneshot=1, then en=1 for 6 cycles -> q goes 3,2,1,0 then holds 0; tc pulses once at q=0; busy falls with q=0 and stays 0.
- Load priority and zero load: load=1 and en=1 on the same edge with load_val=9 -> q=9, no decrement, tc=0. Then load_val=0 with oneshot=1 -> q=0, busy=0, tc=0.
- Enable gating and DONE exit: en toggling 1,0,1,0 from q=5 -> q goes 4,4,3,3. In DONE, en=1 keeps q=0; then load_val=2 -> busy=1 and counting resumes.
- Reset mid-operation: at q=6 assert rst together with load=1 and load_val=A -> q=F, tc=0, busy=1; load is ignored.
- With DOWN_CNT_PRESCALE_EN and PRESCALE=4: load_val=2, en=1 held -> q steps 2 to 1 after 4 cycles, then to 0 after 4 more cycles with a one-cycle tc; a load mid-interval restarts the 4-cycle spacing.
